// File: rtl/grf_read_scoreboard.sv
// GRF read side: 32x32 register file, two bypassed combinational read ports, one writeback
// port and a per-register pending-write scoreboard that stalls decode on outstanding writes.
module grf_read_scoreboard #(
   parameter int CNT_W = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        flush,
   input  logic [4:0]  rs_addr,
   input  logic        rs_used,
   input  logic [4:0]  rt_addr,
   input  logic        rt_used,
   output logic [31:0] rs_data,
   output logic [31:0] rt_data,
   output logic        stall,
   input  logic        iss_valid,
   input  logic        iss_we,
   input  logic [4:0]  iss_waddr,
   output logic        iss_ready,
   input  logic        wb_valid,
   input  logic [4:0]  wb_waddr,
   input  logic [31:0] wb_wdata,
   output logic        sb_err
);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [31:0]      regs [32];
   logic [CNT_W-1:0] cnt  [32];
   logic             sb_err_q;
   logic [31:0]      inc_v;
   logic [31:0]      dec_v;
   logic             rs_busy;
   logic             rt_busy;
   logic             iss_hit;
   logic             full;
   logic             fire;

   // A register retiring its last pending write this cycle is already free (bypass covers data).
   function automatic logic busy_f(input logic [4:0] a, input logic [CNT_W-1:0] c,
                                   input logic hit);
      return (a != 5'd0) && (c != '0) && !(hit && c == CNT_ONE);
   endfunction

   always_comb begin
      rs_data   = (wb_valid && wb_waddr == rs_addr && rs_addr != 5'd0) ? wb_wdata : regs[rs_addr];
      rt_data   = (wb_valid && wb_waddr == rt_addr && rt_addr != 5'd0) ? wb_wdata : regs[rt_addr];
      rs_busy   = busy_f(rs_addr, cnt[rs_addr], wb_valid && wb_waddr == rs_addr);
      rt_busy   = busy_f(rt_addr, cnt[rt_addr], wb_valid && wb_waddr == rt_addr);
      stall     = (rs_used && rs_busy) || (rt_used && rt_busy);
      iss_hit   = wb_valid && wb_waddr == iss_waddr;
      full      = iss_we && iss_waddr != 5'd0 && cnt[iss_waddr] == CNT_MAX && !iss_hit;
      iss_ready = !stall && !full && !flush;
      fire      = iss_valid && iss_ready;
      inc_v     = '0;
      dec_v     = '0;
      for (int i = 1; i < 32; i++) begin
         inc_v[i] = fire && iss_we && iss_waddr == 5'(i);
         dec_v[i] = wb_valid && wb_waddr == 5'(i) && cnt[i] != '0;
      end
   end

   assign sb_err = sb_err_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 32; i++) begin
            regs[i] <= '0;
            cnt[i]  <= '0;
         end
         sb_err_q <= 1'b0;
      end else begin
         if (wb_valid && wb_waddr != 5'd0)
            regs[wb_waddr] <= wb_wdata;
         // Writeback with nothing pending means the scoreboard lost track; a flush cycle is exempt.
         if (!flush && wb_valid && wb_waddr != 5'd0 && cnt[wb_waddr] == '0)
            sb_err_q <= 1'b1;
         for (int i = 1; i < 32; i++) begin
            if (flush)
               cnt[i] <= '0;
            else if (inc_v[i] && !dec_v[i])
               cnt[i] <= cnt[i] + CNT_ONE;
            else if (dec_v[i] && !inc_v[i])
               cnt[i] <= cnt[i] - CNT_ONE;
         end
      end
   end
endmodule

// File: tb/tb_grf_read_scoreboard.sv
// Directed, table-driven bench for grf_read_scoreboard: one record per clock cycle of inputs
// with the combinational outputs expected during that cycle, plus an asynchronous reset pulse.
module tb_grf_read_scoreboard;
   logic        clk = 1'b0;
   logic        reset_n;
   logic        flush;
   logic [4:0]  rs_addr;
   logic        rs_used;
   logic [4:0]  rt_addr;
   logic        rt_used;
   logic [31:0] rs_data;
   logic [31:0] rt_data;
   logic        stall;
   logic        iss_valid;
   logic        iss_we;
   logic [4:0]  iss_waddr;
   logic        iss_ready;
   logic        wb_valid;
   logic [4:0]  wb_waddr;
   logic [31:0] wb_wdata;
   logic        sb_err;

   int n_cmp = 0;
   int n_bad = 0;

   grf_read_scoreboard #(.CNT_W(2)) dut (
      .clk(clk), .reset_n(reset_n), .flush(flush),
      .rs_addr(rs_addr), .rs_used(rs_used), .rt_addr(rt_addr), .rt_used(rt_used),
      .rs_data(rs_data), .rt_data(rt_data), .stall(stall),
      .iss_valid(iss_valid), .iss_we(iss_we), .iss_waddr(iss_waddr), .iss_ready(iss_ready),
      .wb_valid(wb_valid), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata), .sb_err(sb_err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        flush;
      logic [4:0]  rs;
      logic        rsu;
      logic [4:0]  rt;
      logic        rtu;
      logic        iv;
      logic        iwe;
      logic [4:0]  iw;
      logic        wv;
      logic [4:0]  ww;
      logic [31:0] wd;
      logic [31:0] ers;
      logic [31:0] ert;
      logic        est;
      logic        erdy;
      logic        eerr;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input vec_t t);
      vecs.push_back(t);
   endtask

   task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s vec %0d: got %h expected %h", nm, idx, act, exp);
      end
   endtask

   task automatic run_vec(input int idx);
      vec_t t;
      t = vecs[idx];
      flush     = t.flush;
      rs_addr   = t.rs;
      rs_used   = t.rsu;
      rt_addr   = t.rt;
      rt_used   = t.rtu;
      iss_valid = t.iv;
      iss_we    = t.iwe;
      iss_waddr = t.iw;
      wb_valid  = t.wv;
      wb_waddr  = t.ww;
      wb_wdata  = t.wd;
      #2;
      chk("rs_data", idx, rs_data, t.ers);
      chk("rt_data", idx, rt_data, t.ert);
      chk("stall", idx, 32'(stall), 32'(t.est));
      chk("iss_ready", idx, 32'(iss_ready), 32'(t.erdy));
      chk("sb_err", idx, 32'(sb_err), 32'(t.eerr));
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      flush = 0; rs_addr = 0; rs_used = 0; rt_addr = 0; rt_used = 0;
      iss_valid = 0; iss_we = 0; iss_waddr = 0; wb_valid = 0; wb_waddr = 0; wb_wdata = 0;
   endtask

   int reset_at;

   initial begin
      //    fl rs rsu rt rtu iv iwe iw wv ww wd           ers           ert           st rdy err
      add('{0, 5, 1, 31, 1, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        0, 1, 0}); // 0 reset state
      add('{0, 0, 0, 0,  0, 1, 1, 8, 0, 0, 32'h0,        32'h0,        32'h0,        0, 1, 0}); // 1 issue $8
      add('{0, 8, 1, 0,  0, 1, 1, 2, 0, 0, 32'h0,        32'h0,        32'h0,        1, 0, 0}); // 2 read pending $8
      add('{0, 8, 1, 0,  0, 0, 0, 0, 1, 8, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0,        0, 1, 0}); // 3 wb bypass
      add('{0, 8, 1, 8,  1, 0, 0, 0, 0, 0, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 0, 1, 0}); // 4 stored, free
      add('{0, 0, 0, 0,  0, 1, 1, 9, 0, 0, 32'h0,        32'h0,        32'h0,        0, 1, 0}); // 5 issue $9 #1
      add('{0, 0, 0, 0,  0, 1, 1, 9, 0, 0, 32'h0,        32'h0,        32'h0,        0, 1, 0}); // 6 issue $9 #2
      add('{0, 0, 0, 0,  0, 1, 1, 9, 0, 0, 32'h0,        32'h0,        32'h0,        0, 1, 0}); // 7 issue $9 #3
      add('{0, 0, 0, 0,  0, 1, 1, 9, 0, 0, 32'h0,        32'h0,        32'h0,        0, 0, 0}); // 8 full
      add('{0, 9, 0, 0,  0, 1, 1, 9, 1, 9, 32'h99,       32'h99,       32'h0,        0, 1, 0}); // 9 full + wb
      add('{0, 9, 0, 0,  0, 1, 1, 9, 0, 0, 32'h0,        32'h99,       32'h0,        0, 0, 0}); // 10 still 3
      add('{0, 9, 1, 0,  0, 0, 0, 0, 1, 9, 32'hA1,       32'hA1,       32'h0,        1, 0, 0}); // 11 3->2 stalls
      add('{0, 0, 0, 0,  0, 0, 0, 0, 1, 9, 32'hA2,       32'h0,        32'h0,        0, 1, 0}); // 12 2->1
      add('{0, 0, 0, 0,  0, 0, 0, 0, 1, 9, 32'hA3,       32'h0,        32'h0,        0, 1, 0}); // 13 1->0
      add('{0, 9, 1, 9,  1, 0, 0, 0, 0, 0, 32'h0,        32'hA3,       32'hA3,       0, 1, 0}); // 14 drained
      add('{0, 0, 1, 0,  1, 1, 1, 0, 1, 0, 32'h1234,     32'h0,        32'h0,        0, 1, 0}); // 15 $0 issue+wb
      add('{0, 0, 1, 0,  1, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        0, 1, 0}); // 16 $0 still 0
      add('{0, 12, 1, 0, 0, 0, 0, 0, 1, 12, 32'h55,      32'h55,       32'h0,        0, 1, 0}); // 17 underflow wb
      add('{0, 12, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h55,       32'h0,        0, 1, 1}); // 18 sb_err set
      add('{0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        0, 1, 1}); // 19 sticky
      add('{0, 0, 0, 0,  0, 1, 1, 3, 0, 0, 32'h0,        32'h0,        32'h0,        0, 1, 1}); // 20 issue $3
      add('{0, 0, 0, 0,  0, 1, 1, 4, 0, 0, 32'h0,        32'h0,        32'h0,        0, 1, 1}); // 21 issue $4
      add('{1, 4, 0, 0,  0, 1, 1, 5, 1, 3, 32'h77,       32'h0,        32'h0,        0, 0, 1}); // 22 flush
      add('{0, 4, 1, 3,  1, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h77,       0, 1, 1}); // 23 cleared
      add('{0, 5, 1, 0,  0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        0, 1, 1}); // 24 no issue
      reset_at = vecs.size();
      add('{0, 8, 1, 9,  1, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        0, 1, 0}); // 25 regs cleared
      add('{1, 7, 1, 0,  0, 0, 0, 0, 1, 7, 32'h70,       32'h70,       32'h0,        0, 0, 0}); // 26 flush wb cnt0
      add('{0, 7, 1, 0,  0, 0, 0, 0, 0, 0, 32'h0,        32'h70,       32'h0,        0, 1, 0}); // 27 no sb_err
      add('{0, 6, 1, 0,  0, 1, 1, 6, 0, 0, 32'h0,        32'h0,        32'h0,        0, 1, 0}); // 28 self-dep
      add('{0, 6, 1, 0,  0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        1, 0, 0}); // 29 now pending
      add('{0, 6, 1, 6,  1, 0, 0, 0, 1, 6, 32'h66,       32'h66,       32'h66,       0, 1, 0}); // 30 retire
      add('{0, 6, 1, 0,  0, 0, 0, 0, 1, 6, 32'h67,       32'h67,       32'h0,        0, 1, 0}); // 31 underflow
      add('{0, 6, 1, 0,  0, 0, 0, 0, 0, 0, 32'h0,        32'h67,       32'h0,        0, 1, 1}); // 32 sb_err set

      idle_inputs();
      reset_n = 1'b0;
      #12;
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < reset_at; i++)
         run_vec(i);

      // Asynchronous reset pulse between clock edges with live state in the file.
      idle_inputs();
      rs_addr = 5'd8; rs_used = 1; rt_addr = 5'd3; rt_used = 1;
      #1;
      chk("pre_reset_rt", -1, rt_data, 32'h77);
      chk("pre_reset_err", -1, 32'(sb_err), 32'h1);
      #1;
      reset_n = 1'b0;
      #1;
      chk("async_rs", -1, rs_data, 32'h0);
      chk("async_rt", -1, rt_data, 32'h0);
      chk("async_err", -1, 32'(sb_err), 32'h0);
      chk("async_stall", -1, 32'(stall), 32'h0);
      @(posedge clk);
      #3;
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = reset_at; i < vecs.size(); i++)
         run_vec(i);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
